disk_track_cache: RTL and testbench
===================================

Name: disk_track_cache

Overview:
Single-track floppy cache feeding the Apple II Disk II emulation inside apple2_top. When the head's track number changes, or a new image is mounted, it requests 13 consecutive 512-byte SD sectors starting at LBA 13*track. It stores them in a 6656-byte dual-port RAM. The disk controller reads nibbles from that RAM by track offset.

Parameters:
SECS_PER_TRACK, 13, sectors per track; the LBA multiplier.
TRACK_W, 6, track number width.
ADDR_W, 14, buffer address width ({sector[3:0], byte[8:0]}, MSB of 14 tied 0 on write side).
DATA_W, 8, buffer data width.

Ports:
CLK_VIDEO  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high.
track  in  TRACK_W  current head track from controller.
img_mounted  in  1  one-cycle pulse: image (re)mounted.
img_size  in  64  mounted image size; 0 = no image.
sd_lba  out  32  sector LBA requested.
sd_rd  out  1  sector read request, level.
sd_ack  in  1  host ack; high for duration of one sector transfer.
sd_buff_addr  in  9  byte index within sector.
sd_buff_dout  in  8  sector byte from host.
sd_buff_wr  in  1  byte strobe (valid only while sd_ack=1).
fd_track_addr  in  ADDR_W  controller read/write offset in track.
fd_data_in  out  8  buffer byte at fd_track_addr.
fd_we  in  1  controller write strobe (see Optional Feature).
fd_data_do  in  8  controller write data.
cpu_wait  out  1  stall CPU while track loads.

Behaviour:
- Reset values: sd_rd=0, cpu_wait=0, sd_lba=0, state=IDLE, valid=0, mounted_flag=0, sec_cnt=0. fd_data_in follows RAM and is not reset. RAM contents are kept across reset.
- old_ack register samples sd_ack every cycle. Edges: rise = ~old_ack & sd_ack; fall = old_ack & ~sd_ack.
- mounted_flag <= mounted_flag | img_mounted each cycle.
- IDLE: a reload triggers when (~valid) | (cur_track != track) | (mounted_flag & ~img_mounted). On trigger:
  - cur_track <= track; valid <= 1; mounted_flag <= 0.
  - If img_size != 0: sec_cnt <= 0; sd_lba <= SECS_PER_TRACK*track (zero-extended, 32 bits); sd_rd <= 1; cpu_wait <= 1; state <= LOAD.
  - If img_size == 0: stay IDLE; the buffer is not touched.
- LOAD:
  - On rise: sd_lba <= sd_lba+1. If sec_cnt >= 12, sd_rd <= 0.
  - On fall: sec_cnt <= sec_cnt+1. If sd_rd==0 (last sector done): state <= IDLE and cpu_wait <= 0.
  - cpu_wait stays 1 for the whole 13-sector load.
  - A track change during LOAD is ignored until IDLE; the next IDLE cycle then reloads.
- Buffer write port A: we = sd_buff_wr & sd_ack; addr = {1'b0, sec_cnt, sd_buff_addr}. Bytes 0..6655 are filled.
- Buffer read port B: fd_data_in is registered, 1-cycle latency after fd_track_addr. Addresses at or above 6656 return stale/undefined RAM content.
- Read-during-write on the same address across ports returns old data.
- Reset mid-LOAD: drops sd_rd and cpu_wait immediately. valid=0 forces a full reload on the next cycle after reset.

Optional Feature:
TRACK_WRITE_EN
- Defined: port B writes fd_data_do at fd_track_addr when fd_we=1. Port B read data shows the written byte (write-first).
- Undefined: fd_we and fd_data_do are ignored and port B is read-only.
- No write-back to SD in either case.

Decomposition:
- Package disk_cache_pkg: SECS_PER_TRACK, SECTOR_BYTES=512, TRACK_BYTES=6656, state enum {IDLE, LOAD}.
- Sub-module dpram_tc: generic true dual-port synchronous RAM parameterised by DATA_W/ADDR_W, one clock, registered q on each port. It replaces the external bram.

Test Plan:
- Reset, track=0, img_size=143360: next cycle sd_rd=1, cpu_wait=1, sd_lba=0. Emulate 13 ack pulses → sd_lba ends at 13, sd_rd drops on the 13th rise, cpu_wait=0 after the 13th fall.
- Track 0→5 in IDLE: sd_lba=65, sd_rd=1. Sector k byte b written with value (k+b)&FF; read fd_track_addr=k*512+b → correct byte one cycle later.
- img_size=0 with track change: sd_rd and cpu_wait stay 0; the buffer is unchanged.
- img_mounted pulse with unchanged track=5: the load of LBA 65..77 is reissued.
- Track change to 7 mid-LOAD of track 5: load of 5 completes (13 sectors), then a load at LBA 91 starts.
- reset asserted during sector 4: sd_rd=0 and cpu_wait=0 the next cycle; after release, reload starts at LBA 13*track. With TRACK_WRITE_EN, an fd_we write of 0xA5 at 0x0100 reads back 0xA5.

Source files
------------

// File: rtl/disk_cache_pkg.sv
// Shared constants and types for the single-track floppy cache.
package disk_cache_pkg;

  localparam int unsigned SECS_PER_TRACK = 13;
  localparam int unsigned SECTOR_BYTES   = 512;
  localparam int unsigned TRACK_BYTES    = SECS_PER_TRACK * SECTOR_BYTES;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/dpram_tc.sv
// Generic true dual-port synchronous RAM, single clock, registered read on
// each port. A port that writes sees its own new data; the other port reading
// the same address in that cycle sees the old contents.
module dpram_tc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] d_a,
  output logic [DATA_W-1:0] q_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] d_b,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] q_a_d, q_a_q;
  logic [DATA_W-1:0] q_b_d, q_b_q;

  // Read data for each port: own write wins, otherwise the stored word.
  always_comb begin
    q_a_d = we_a ? d_a : mem[addr_a];
    q_b_d = we_b ? d_b : mem[addr_b];
  end

  // Array writes and registered read data.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= d_a;
    if (we_b) mem[addr_b] <= d_b;
    q_a_q <= q_a_d;
    q_b_q <= q_b_d;
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: rtl/disk_track_cache.sv
// Single-track floppy cache: on a track change or image mount it pulls the
// 13 SD sectors of the current track into a local buffer and stalls the CPU
// until the track is resident. The disk controller reads the buffer by offset.
// Build option TRACK_WRITE_EN: lets the controller write into the buffer
// (write-first on its port); without it the controller port is read-only.
// Nothing is ever written back to SD.
//
// state | meaning
// IDLE  | track resident (or no image); watch for track change / mount
// LOAD  | streaming 13 sectors from SD, cpu_wait held high
module disk_track_cache
  import disk_cache_pkg::*;
#(
  parameter int TRACK_W = 6,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8
) (
  input  logic               CLK_VIDEO,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic [63:0]        img_size,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  input  logic               sd_ack,
  input  logic [8:0]         sd_buff_addr,
  input  logic [7:0]         sd_buff_dout,
  input  logic               sd_buff_wr,
  input  logic [ADDR_W-1:0]  fd_track_addr,
  output logic [DATA_W-1:0]  fd_data_in,
  input  logic               fd_we,
  input  logic [DATA_W-1:0]  fd_data_do,
  output logic               cpu_wait
);

  state_t             state_q, state_d;
  logic               old_ack_q, old_ack_d;
  logic               mounted_flag_q, mounted_flag_d;
  logic               valid_q, valid_d;
  logic [TRACK_W-1:0] cur_track_q, cur_track_d;
  logic [3:0]         sec_cnt_q, sec_cnt_d;
  logic [31:0]        sd_lba_q, sd_lba_d;
  logic               sd_rd_q, sd_rd_d;
  logic               cpu_wait_q, cpu_wait_d;

  logic ack_rise, ack_fall, reload;

  assign ack_rise = ~old_ack_q & sd_ack;
  assign ack_fall = old_ack_q & ~sd_ack;
  assign reload   = ~valid_q | (cur_track_q != track) | (mounted_flag_q & ~img_mounted);

  // Next-state and output logic for the track loader.
  always_comb begin
    state_d        = state_q;
    old_ack_d      = sd_ack;
    mounted_flag_d = mounted_flag_q | img_mounted;
    valid_d        = valid_q;
    cur_track_d    = cur_track_q;
    sec_cnt_d      = sec_cnt_q;
    sd_lba_d       = sd_lba_q;
    sd_rd_d        = sd_rd_q;
    cpu_wait_d     = cpu_wait_q;
    case (state_q)
      IDLE: begin
        if (reload) begin
          cur_track_d    = track;
          valid_d        = 1'b1;
          mounted_flag_d = 1'b0;
          // With no image the track is marked current but nothing is fetched.
          if (img_size != 64'd0) begin
            sec_cnt_d  = 4'd0;
            sd_lba_d   = 32'(SECS_PER_TRACK) * 32'(track);
            sd_rd_d    = 1'b1;
            cpu_wait_d = 1'b1;
            state_d    = LOAD;
          end
        end
      end
      LOAD: begin
        if (ack_rise) begin
          sd_lba_d = sd_lba_q + 32'd1;
          if (sec_cnt_q >= 4'(SECS_PER_TRACK - 1)) sd_rd_d = 1'b0;
        end
        if (ack_fall) begin
          sec_cnt_d = sec_cnt_q + 4'd1;
          if (!sd_rd_q) begin
            state_d    = IDLE;
            cpu_wait_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader registers with synchronous reset; the ack history always samples.
  always_ff @(posedge CLK_VIDEO) begin
    old_ack_q <= old_ack_d;
    if (reset) begin
      state_q        <= IDLE;
      mounted_flag_q <= 1'b0;
      valid_q        <= 1'b0;
      cur_track_q    <= '0;
      sec_cnt_q      <= 4'd0;
      sd_lba_q       <= 32'd0;
      sd_rd_q        <= 1'b0;
      cpu_wait_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      mounted_flag_q <= mounted_flag_d;
      valid_q        <= valid_d;
      cur_track_q    <= cur_track_d;
      sec_cnt_q      <= sec_cnt_d;
      sd_lba_q       <= sd_lba_d;
      sd_rd_q        <= sd_rd_d;
      cpu_wait_q     <= cpu_wait_d;
    end
  end

  assign sd_lba   = sd_lba_q;
  assign sd_rd    = sd_rd_q;
  assign cpu_wait = cpu_wait_q;

  logic              buf_we_a;
  logic [ADDR_W-1:0] buf_addr_a;
  logic              buf_we_b;
  logic [DATA_W-1:0] buf_q_a_unused;

  assign buf_we_a   = sd_buff_wr & sd_ack;
  assign buf_addr_a = {1'b0, sec_cnt_q, sd_buff_addr};

`ifdef TRACK_WRITE_EN
  assign buf_we_b = fd_we;
`else
  logic unused_fd_we;
  assign unused_fd_we = fd_we;
  assign buf_we_b     = 1'b0;
`endif

  dpram_tc #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk    (CLK_VIDEO),
    .we_a   (buf_we_a),
    .addr_a (buf_addr_a),
    .d_a    (sd_buff_dout),
    .q_a    (buf_q_a_unused),
    .we_b   (buf_we_b),
    .addr_b (fd_track_addr),
    .d_b    (fd_data_do),
    .q_b    (fd_data_in)
  );

endmodule

// File: tb/tb_disk_track_cache.sv
// Directed bench for disk_track_cache: emulates the SD host handshake and
// checks LBA sequencing, stalls, buffer contents and reset/mount behaviour.
module tb_disk_track_cache;

  logic        CLK_VIDEO;
  logic        reset;
  logic [5:0]  track;
  logic        img_mounted;
  logic [63:0] img_size;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [13:0] fd_track_addr;
  logic [7:0]  fd_data_in;
  logic        fd_we;
  logic [7:0]  fd_data_do;
  logic        cpu_wait;

  int checks   = 0;
  int failures = 0;

  disk_track_cache dut (
    .CLK_VIDEO     (CLK_VIDEO),
    .reset         (reset),
    .track         (track),
    .img_mounted   (img_mounted),
    .img_size      (img_size),
    .sd_lba        (sd_lba),
    .sd_rd         (sd_rd),
    .sd_ack        (sd_ack),
    .sd_buff_addr  (sd_buff_addr),
    .sd_buff_dout  (sd_buff_dout),
    .sd_buff_wr    (sd_buff_wr),
    .fd_track_addr (fd_track_addr),
    .fd_data_in    (fd_data_in),
    .fd_we         (fd_we),
    .fd_data_do    (fd_data_do),
    .cpu_wait      (cpu_wait)
  );

  initial begin
    CLK_VIDEO = 1'b0;
    forever #5 CLK_VIDEO = ~CLK_VIDEO;
  end

  task automatic tick();
    @(posedge CLK_VIDEO);
    #1;
  endtask

  task automatic read_byte(input int addr, output logic [7:0] data);
    fd_track_addr = 14'(addr);
    tick();
    data = fd_data_in;
  endtask

  // One host sector transfer: ack high, nbytes strobed, ack low.
  task automatic do_sector(input int base, input int k, input int nbytes, input logic [7:0] seed);
    logic exp_rd;
    logic exp_wait;
    checks++;
    if ({sd_rd, cpu_wait, sd_lba} !== {1'b1, 1'b1, 32'(base + k)}) begin
      failures++;
      $display("FAIL sector_start k=%0d rd/wait/lba=%b/%b/%0d want 1/1/%0d", k, sd_rd, cpu_wait, sd_lba, base + k);
    end
    sd_ack = 1'b1;
    tick();
    exp_rd = (k != 12);
    checks++;
    if (sd_rd !== exp_rd) begin
      failures++;
      $display("FAIL rd_after_rise k=%0d got %b want %b", k, sd_rd, exp_rd);
    end
    for (int b = 0; b < nbytes; b++) begin
      sd_buff_addr = 9'(b);
      sd_buff_dout = seed + 8'(k + b);
      sd_buff_wr   = 1'b1;
      tick();
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    tick();
    exp_wait = (k != 12);
    checks++;
    if (cpu_wait !== exp_wait) begin
      failures++;
      $display("FAIL wait_after_fall k=%0d got %b want %b", k, cpu_wait, exp_wait);
    end
  endtask

  task automatic load_track(input int base, input int nbytes, input logic [7:0] seed);
    for (int k = 0; k < 13; k++) do_sector(base, k, nbytes, seed);
    checks++;
    if ({sd_rd, cpu_wait, sd_lba} !== {1'b0, 1'b0, 32'(base + 13)}) begin
      failures++;
      $display("FAIL load_end rd/wait/lba=%b/%b/%0d want 0/0/%0d", sd_rd, cpu_wait, sd_lba, base + 13);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({sd_rd, cpu_wait, sd_lba} !== {1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset_values rd/wait/lba=%b/%b/%0d want 0/0/0", sd_rd, cpu_wait, sd_lba);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({sd_rd, cpu_wait, sd_lba} !== {1'b1, 1'b1, 32'd0}) begin
      failures++;
      $display("FAIL first_load rd/wait/lba=%b/%b/%0d want 1/1/0", sd_rd, cpu_wait, sd_lba);
    end
  endtask

  task automatic test_load_track0();
    load_track(0, 4, 8'h40);
    tick();
    checks++;
    if (sd_rd !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_reload got %b want 0", sd_rd);
    end
  endtask

  task automatic test_track_change();
    int addrs [6] = '{0, 511, 512, 2660, 6144, 6655};
    logic [7:0] got;
    logic [7:0] exp;
    track = 6'd5;
    tick();
    checks++;
    if ({sd_rd, cpu_wait, sd_lba} !== {1'b1, 1'b1, 32'd65}) begin
      failures++;
      $display("FAIL track5_start rd/wait/lba=%b/%b/%0d want 1/1/65", sd_rd, cpu_wait, sd_lba);
    end
    load_track(65, 512, 8'h00);
    foreach (addrs[i]) begin
      read_byte(addrs[i], got);
      exp = 8'((addrs[i] / 512) + (addrs[i] % 512));
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL read addr=%0d got %h want %h", addrs[i], got, exp);
      end
    end
  endtask

  task automatic test_no_image();
    logic [7:0] got;
    img_size = 64'd0;
    track    = 6'd9;
    repeat (3) tick();
    checks++;
    if ({sd_rd, cpu_wait, sd_lba} !== {1'b0, 1'b0, 32'd78}) begin
      failures++;
      $display("FAIL no_image rd/wait/lba=%b/%b/%0d want 0/0/78", sd_rd, cpu_wait, sd_lba);
    end
    track = 6'd5;
    repeat (2) tick();
    img_size = 64'd143360;
    repeat (2) tick();
    checks++;
    if ({sd_rd, cpu_wait} !== 2'b00) begin
      failures++;
      $display("FAIL no_image_back rd/wait=%b/%b want 0/0", sd_rd, cpu_wait);
    end
    read_byte(2660, got);
    checks++;
    if (got !== 8'h69) begin
      failures++;
      $display("FAIL no_image_buf got %h want 69", got);
    end
  endtask

  task automatic test_remount();
    logic [7:0] got;
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    checks++;
    if (sd_rd !== 1'b0) begin
      failures++;
      $display("FAIL remount_early got %b want 0", sd_rd);
    end
    tick();
    load_track(65, 4, 8'h80);
    read_byte(2 * 512 + 3, got);
    checks++;
    if (got !== 8'h85) begin
      failures++;
      $display("FAIL remount_data got %h want 85", got);
    end
    read_byte(2660, got);
    checks++;
    if (got !== 8'h69) begin
      failures++;
      $display("FAIL remount_keep got %h want 69", got);
    end
  endtask

  task automatic test_track_change_mid_load();
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    tick();
    for (int k = 0; k < 13; k++) begin
      if (k == 4) track = 6'd7;
      do_sector(65, k, 2, 8'h80);
    end
    checks++;
    if (sd_lba !== 32'd78) begin
      failures++;
      $display("FAIL mid_load_end lba got %0d want 78", sd_lba);
    end
    tick();
    checks++;
    if ({sd_rd, cpu_wait, sd_lba} !== {1'b1, 1'b1, 32'd91}) begin
      failures++;
      $display("FAIL track7_start rd/wait/lba=%b/%b/%0d want 1/1/91", sd_rd, cpu_wait, sd_lba);
    end
    load_track(91, 2, 8'h30);
  endtask

  task automatic test_reset_mid_load();
    track = 6'd3;
    tick();
    for (int k = 0; k < 4; k++) do_sector(39, k, 1, 8'h30);
    sd_ack = 1'b1;
    tick();
    sd_buff_addr = 9'd0;
    sd_buff_dout = 8'h11;
    sd_buff_wr   = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({sd_rd, cpu_wait} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_load rd/wait=%b/%b want 0/0", sd_rd, cpu_wait);
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({sd_rd, cpu_wait, sd_lba} !== {1'b1, 1'b1, 32'd39}) begin
      failures++;
      $display("FAIL reload_after_reset rd/wait/lba=%b/%b/%0d want 1/1/39", sd_rd, cpu_wait, sd_lba);
    end
    load_track(39, 1, 8'h30);
  endtask

  task automatic test_track_write();
    logic [7:0] got;
    logic [7:0] exp;
`ifdef TRACK_WRITE_EN
    exp = 8'hA5;
`else
    exp = 8'h00;
`endif
    fd_track_addr = 14'h0100;
    fd_data_do    = 8'hA5;
    fd_we         = 1'b1;
    tick();
    fd_we = 1'b0;
    checks++;
    if (fd_data_in !== exp) begin
      failures++;
      $display("FAIL wr_same_cycle got %h want %h", fd_data_in, exp);
    end
    read_byte(14'h0100, got);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL wr_readback got %h want %h", got, exp);
    end
    read_byte(14'h0101, got);
    checks++;
    if (got !== 8'h01) begin
      failures++;
      $display("FAIL wr_neighbour got %h want 01", got);
    end
  endtask

  initial begin
    reset         = 1'b1;
    track         = 6'd0;
    img_mounted   = 1'b0;
    img_size      = 64'd143360;
    sd_ack        = 1'b0;
    sd_buff_addr  = 9'd0;
    sd_buff_dout  = 8'd0;
    sd_buff_wr    = 1'b0;
    fd_track_addr = 14'd0;
    fd_we         = 1'b0;
    fd_data_do    = 8'd0;
    test_reset();
    test_load_track0();
    test_track_change();
    test_no_image();
    test_remount();
    test_track_change_mid_load();
    test_reset_mid_load();
    test_track_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
